// File: rtl/hockey_pkg.sv
// Shared constants for the hockey game display path.
// State codes, 4-bit character codes, segment patterns, numeric helper.
package hockey_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_DISP   = 4'd1;
    localparam logic [3:0] ST_HIT_A  = 4'd2;
    localparam logic [3:0] ST_HIT_B  = 4'd3;
    localparam logic [3:0] ST_SEND_A = 4'd4;
    localparam logic [3:0] ST_SEND_B = 4'd5;
    localparam logic [3:0] ST_RESP_A = 4'd6;
    localparam logic [3:0] ST_RESP_B = 4'd7;
    localparam logic [3:0] ST_GOAL_A = 4'd8;
    localparam logic [3:0] ST_GOAL_B = 4'd9;
    localparam logic [3:0] ST_END    = 4'd10;

    localparam logic [3:0] CH_0     = 4'h0;
    localparam logic [3:0] CH_1     = 4'h1;
    localparam logic [3:0] CH_2     = 4'h2;
    localparam logic [3:0] CH_3     = 4'h3;
    localparam logic [3:0] CH_4     = 4'h4;
    localparam logic [3:0] CH_A     = 4'hA;
    localparam logic [3:0] CH_B     = 4'hB;
    localparam logic [3:0] CH_DASH  = 4'hD;
    localparam logic [3:0] CH_E     = 4'hE;
    localparam logic [3:0] CH_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Values above 4 cannot be drawn as digits and show as 'E'.
    function automatic logic [3:0] num_char(input logic [2:0] v);
        return (v > 3'd4) ? CH_E : {1'b0, v};
    endfunction

endpackage

// File: rtl/hockey_display_if.sv
// Game-state bundle from the hockey FSM to the display stage.
// master: game FSM drives; slave: display consumes.
interface hockey_display_if;
    logic [3:0] state_in;
    logic [2:0] x_in;
    logic [2:0] y_in;
    logic [1:0] score_a;
    logic [1:0] score_b;

    modport master (output state_in, x_in, y_in, score_a, score_b);
    modport slave  (input  state_in, x_in, y_in, score_a, score_b);
endinterface

// File: rtl/ssd_encode.sv
// Character code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Ports: ch (4-bit code in), seg (7-bit pattern out). Combinational.
module ssd_encode
    import hockey_pkg::*;
(
    input  logic [3:0] ch,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (ch)
            CH_0:    seg = SEG_0;
            CH_1:    seg = SEG_1;
            CH_2:    seg = SEG_2;
            CH_3:    seg = SEG_3;
            CH_4:    seg = SEG_4;
            CH_A:    seg = SEG_A;
            CH_B:    seg = SEG_B;
            CH_DASH: seg = SEG_DASH;
            CH_E:    seg = SEG_E;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/hockey_display.sv
// Hockey output stage: 8-digit multiplexed display, player LEDs, puck bar.
// Ports: clk, rst (async high), game (slave bundle), AN, SEG, LEDA, LEDB, LEDX.
module hockey_display
    import hockey_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_SWEEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    hockey_display_if.slave  game,
    output logic [7:0]       AN,
    output logic [6:0]       SEG,
    output logic             LEDA,
    output logic             LEDB,
    output logic [4:0]       LEDX
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_SWEEPS > 1) ? $clog2(BLINK_SWEEPS) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_SWEEPS - 1);

    logic [RW-1:0] ref_cnt;
    logic [2:0]    digit;
    logic [BW-1:0] blk_cnt;
    logic          hidden;
    logic [3:0]    prev_state;

    logic          chg;
    logic          hide;
    logic          win_a;
    logic [3:0]    ch;
    logic [6:0]    seg_nx;
    logic          leda_nx;
    logic          ledb_nx;
    logic [4:0]    ledx_nx;

    assign chg   = (game.state_in != prev_state);
    // A state change shows the new screen visible on its very first cycle.
    assign hide  = hidden && !chg;
    assign win_a = (game.score_a == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt    <= '0;
            digit      <= '0;
            blk_cnt    <= '0;
            hidden     <= 1'b0;
            prev_state <= ST_IDLE;
        end else begin
            prev_state <= game.state_in;
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                digit   <= digit + 3'd1;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            if (chg) begin
                blk_cnt <= '0;
                hidden  <= 1'b0;
            end else if (ref_cnt == REF_LAST && digit == 3'd7) begin
                if (blk_cnt == BLK_LAST) begin
                    blk_cnt <= '0;
                    hidden  <= ~hidden;
                end else begin
                    blk_cnt <= blk_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        ch = CH_BLANK;
        case (game.state_in)
            ST_IDLE: ch = CH_DASH;
            ST_DISP, ST_GOAL_A, ST_GOAL_B: begin
                case (digit)
                    3'd7:    ch = CH_A;
                    3'd6:    ch = num_char({1'b0, game.score_a});
                    3'd1:    ch = num_char({1'b0, game.score_b});
                    3'd0:    ch = CH_B;
                    default: ch = CH_BLANK;
                endcase
                if (hide && game.state_in == ST_GOAL_A && digit >= 3'd6)
                    ch = CH_BLANK;
                if (hide && game.state_in == ST_GOAL_B && digit <= 3'd1)
                    ch = CH_BLANK;
            end
            ST_HIT_A, ST_HIT_B, ST_SEND_A,
            ST_SEND_B, ST_RESP_A, ST_RESP_B: begin
                case (digit)
                    3'd7:    ch = num_char(game.x_in);
                    3'd6:    ch = num_char(game.y_in);
                    3'd1:    ch = num_char({1'b0, game.score_a});
                    3'd0:    ch = num_char({1'b0, game.score_b});
                    default: ch = CH_BLANK;
                endcase
            end
            ST_END: begin
                case (digit)
                    3'd7:    ch = win_a ? CH_A : CH_B;
                    3'd6:    ch = num_char({1'b0,
                                 win_a ? game.score_a : game.score_b});
                    3'd1:    ch = num_char({1'b0, game.score_a});
                    3'd0:    ch = num_char({1'b0, game.score_b});
                    default: ch = CH_BLANK;
                endcase
                if (hide)
                    ch = CH_BLANK;
            end
            default: ch = CH_E;
        endcase
    end

    ssd_encode u_enc (
        .ch  (ch),
        .seg (seg_nx)
    );

    always_comb begin
        leda_nx = (game.state_in == ST_HIT_A) || (game.state_in == ST_RESP_A)
               || (game.state_in == ST_END && win_a);
        ledb_nx = (game.state_in == ST_HIT_B) || (game.state_in == ST_RESP_B)
               || (game.state_in == ST_END && !win_a);
        ledx_nx = '0;
        if (game.state_in >= ST_HIT_A && game.state_in <= ST_GOAL_B
            && game.x_in <= 3'd4)
            ledx_nx = 5'd1 << game.x_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN   <= 8'hFF;
            SEG  <= SEG_BLANK;
            LEDA <= 1'b0;
            LEDB <= 1'b0;
            LEDX <= '0;
        end else begin
            AN   <= ~(8'd1 << digit);
            SEG  <= seg_nx;
            LEDA <= leda_nx;
            LEDB <= ledb_nx;
            LEDX <= ledx_nx;
        end
    end
endmodule

// File: tb/tb_hockey_display.sv
// Testbench for hockey_display with a cycle-count based reference model.
// Ports: none; drives the game bundle, checks AN/SEG/LEDs every cycle.
module tb_hockey_display;
    localparam int DIV = 4;
    localparam int BS  = 2;

    logic       clk;
    logic       rst;
    logic [7:0] AN;
    logic [6:0] SEG;
    logic       LEDA;
    logic       LEDB;
    logic [4:0] LEDX;

    hockey_display_if gif ();

    hockey_display #(.REFRESH_DIV(DIV), .BLINK_SWEEPS(BS)) dut (
        .clk  (clk),
        .rst  (rst),
        .game (gif.slave),
        .AN   (AN),
        .SEG  (SEG),
        .LEDA (LEDA),
        .LEDB (LEDB),
        .LEDX (LEDX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: cycles since reset release, sweeps since last state change.
    int m_k = 0;
    int m_wraps = 0;
    int m_prev = 0;

    function automatic logic [6:0] nseg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            default: return 7'h06;
        endcase
    endfunction

    function automatic logic m_hidden();
        return ((m_wraps / BS) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        int st, x, y, sa, sb, d;
        logic hid, wa;
        logic [6:0] disp [8];
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_a, e_b;
        logic [4:0] e_x;
        st = int'(gif.state_in);
        x  = int'(gif.x_in);
        y  = int'(gif.y_in);
        sa = int'(gif.score_a);
        sb = int'(gif.score_b);
        d  = (m_k / DIV) % 8;
        hid = (st != m_prev) ? 1'b0 : m_hidden();
        wa = (sa == 3);
        for (int i = 0; i < 8; i++) disp[i] = 7'h7F;
        if (st == 0) begin
            for (int i = 0; i < 8; i++) disp[i] = 7'h3F;
        end else if (st == 1 || st == 8 || st == 9) begin
            disp[7] = 7'h08; disp[6] = nseg(sa);
            disp[1] = nseg(sb); disp[0] = 7'h03;
            if (hid && st == 8) begin disp[7] = 7'h7F; disp[6] = 7'h7F; end
            if (hid && st == 9) begin disp[1] = 7'h7F; disp[0] = 7'h7F; end
        end else if (st >= 2 && st <= 7) begin
            disp[7] = nseg(x); disp[6] = nseg(y);
            disp[1] = nseg(sa); disp[0] = nseg(sb);
        end else if (st == 10) begin
            disp[7] = wa ? 7'h08 : 7'h03;
            disp[6] = nseg(wa ? sa : sb);
            disp[1] = nseg(sa); disp[0] = nseg(sb);
            if (hid) for (int i = 0; i < 8; i++) disp[i] = 7'h7F;
        end else begin
            for (int i = 0; i < 8; i++) disp[i] = 7'h06;
        end
        e_an  = 8'hFF;
        e_an[d] = 1'b0;
        e_seg = disp[d];
        e_a = (st == 2) || (st == 6) || (st == 10 && wa);
        e_b = (st == 3) || (st == 7) || (st == 10 && !wa);
        e_x = 5'd0;
        if (st >= 2 && st <= 9 && x <= 4) e_x[x] = 1'b1;
        @(posedge clk);
        #1;
        check("an", AN, e_an);
        check("seg", {1'b0, SEG}, {1'b0, e_seg});
        check("leds", {1'b0, LEDA, LEDB, LEDX}, {1'b0, e_a, e_b, e_x});
        if (st != m_prev) m_wraps = 0;
        else if (m_k % (8 * DIV) == 8 * DIV - 1) m_wraps++;
        m_prev = st;
        m_k++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_an"}, AN, 8'hFF);
        check({tag, "_seg"}, {1'b0, SEG}, 8'h7F);
        check({tag, "_leds"}, {1'b0, LEDA, LEDB, LEDX}, 8'h00);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        m_k = 0;
        m_wraps = 0;
        m_prev = 0;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        gif.state_in = 4'd0;
        gif.x_in = 3'd0;
        gif.y_in = 3'd0;
        gif.score_a = 2'd0;
        gif.score_b = 2'd0;
        #2 rst = 1'b1;
        #1 check_reset("rst0");
        repeat (2) @(posedge clk);
        #1 check_reset("rst1");
        release_rst();

        // Idle scan: dashes on every digit, full sweeps
        steps(70);

        // Send state with fixed puck/score
        gif.state_in = 4'd4; gif.x_in = 3'd2; gif.y_in = 3'd3;
        gif.score_a = 2'd1; gif.score_b = 2'd0;
        steps(40);

        // Goal A blinking, then a change while hidden
        gif.state_in = 4'd8; gif.score_a = 2'd2;
        gif.score_b = 2'($urandom_range(0, 3));
        steps(150);
        n = 0;
        while (!m_hidden() && n < 200) begin step(); n++; end
        check("reach_hidden", {7'd0, m_hidden()}, 8'd1);
        steps(10);
        gif.state_in = 4'd3; gif.x_in = 3'($urandom_range(0, 4));
        steps(40);

        // Goal B blinking
        gif.state_in = 4'd9;
        steps(140);

        // End, B wins
        gif.state_in = 4'd10; gif.score_a = 2'd1; gif.score_b = 2'd3;
        steps(200);
        gif.score_a = 2'd3; gif.score_b = 2'($urandom_range(0, 2));
        steps(20);

        // Out of range puck, then reset mid-digit
        gif.state_in = 4'd5; gif.x_in = 3'd6; gif.y_in = 3'd7;
        steps(37);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        release_rst();
        steps(40);

        // Randomised segments, including invalid state codes
        for (int s = 0; s < 30; s++) begin
            gif.state_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0)
                gif.state_in = 4'($urandom_range(8, 10));
            gif.x_in = 3'($urandom);
            gif.y_in = 3'($urandom);
            gif.score_a = 2'($urandom);
            gif.score_b = 2'($urandom);
            steps($urandom_range(1, 150));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hockey_display.md
Name: hockey_display

Overview:
- Output stage for the hockey game FSM. Consumes the game's state code, puck X/Y coordinates and both scores.
- Drives the board's 8-digit time-multiplexed seven-segment display, the per-player LEDs and the 5-LED puck-column bar.
- Pure consumer: it never feeds back into the game FSM. All outputs are registered.

Parameters:
- REFRESH_DIV, 1000: clk cycles each digit stays lit (>=2).
- BLINK_SWEEPS, 16: full 8-digit sweeps per blink-phase toggle (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- state_in  in  4  game state code (IDLE=0, DISP=1, HIT_A=2, HIT_B=3, SEND_A=4, SEND_B=5, RESP_A=6, RESP_B=7, GOAL_A=8, GOAL_B=9, END=10)
- x_in  in  3  puck X coordinate (valid 0..4)
- y_in  in  3  puck Y coordinate (valid 0..4)
- score_a  in  2  player A score
- score_b  in  2  player B score
- AN  out  8  digit enables, active-low, one-hot-zero
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
- LEDA  out  1  player A prompt
- LEDB  out  1  player B prompt
- LEDX  out  5  puck column, one-hot

Behaviour:
- Reset values: AN=8'hFF, SEG=7'h7F, LEDA=0, LEDB=0, LEDX=0, refresh counter=0, digit index=0, blink counter=0, blink phase=visible.
- Refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index increments (7 wraps to 0).
  - Each wrap of the digit index from 7 to 0 increments the blink counter. At BLINK_SWEEPS it clears and the blink phase toggles.
- AN = ~(1 << digit), registered. SEG is registered in the same cycle as AN, so the two are always coherent.
- Latency: one clk from any input change or digit change to the corresponding SEG/AN/LED value.
- Character encoding:
  - blank=7F, '-'=3F, '0'=40, '1'=79, '2'=24, '3'=30, '4'=19, 'A'=08, 'b'=03, 'E'=06.
  - Numeric values above 4 render as 'E'.
- Digit map (digit 7 leftmost); digits not listed are blank:
  - IDLE: all eight digits '-'.
  - DISP, GOAL_A, GOAL_B: d7='A', d6=score_a, d1=score_b, d0='b'.
  - HIT_A..RESP_B: d7=x_in, d6=y_in, d1=score_a, d0=score_b.
  - END: winner letter on d7 ('A' if score_a==3, else 'b'), d6=winner score, d1=score_a, d0=score_b.
  - Codes 11..15: all digits 'E'.
- Blinking:
  - GOAL_A blanks d7 and d6 while the blink phase is hidden.
  - GOAL_B blanks d1 and d0 while the blink phase is hidden.
  - END blanks all digits while hidden.
  - Other states ignore the blink phase.
- On any change of state_in, the blink counter and phase reset to visible on the next cycle. The refresh counter and digit index are not disturbed.
- LEDs:
  - LEDA=1 in HIT_A, RESP_A, or in END when A is the winner.
  - LEDB=1 in HIT_B, RESP_B, or in END when B is the winner.
  - LEDX=1<<x_in in states 2..9 when x_in<=4; otherwise 0.
- Reset asserted mid-scan forces all outputs to their reset values immediately (asynchronous). Scanning restarts at digit 0 on the first clk after release.

Decomposition:
- Package hockey_pkg:
  - state-code constants shared with the game FSM;
  - 4-bit character codes (CH_0..CH_4, CH_A, CH_B, CH_DASH, CH_E, CH_BLANK);
  - segment constants.
- One sub-module, ssd_encode: combinational 4-bit character code to 7-bit active-low segments.
- Per-digit character selection and all counters stay in hockey_display.

Test Plan (REFRESH_DIV=4, BLINK_SWEEPS=2):
1. Reset released, state_in=0 -> AN=FE for 4 clks, then FD, ... 7F, then FE again. SEG=3F on every digit.
2. state_in=4, x_in=2, y_in=3, scores 1/0 -> digit 7 shows SEG=24, digit 6 shows 30, digit 1 shows 79, digit 0 shows 40. LEDX=00100, LEDA=LEDB=0.
3. state_in=8, score_a=2 -> d7/d6 show 'A'/'2' for 2 sweeps (64 clks), are blank for the next 64, then visible again. d1/d0 never blank.
4. During case 3, state_in changes to 3 in mid-hidden phase -> the next cycle shows all digits visible. LEDB=1, LEDX=one-hot of x_in.
5. state_in=10, score_a=1, score_b=3 -> d7='b' (03), d6='3' (30), LEDB=1, LEDA=0. All digits blank on alternate 64-clk windows.
6. x_in=6 in state 5 -> d7 shows 'E' (06), LEDX=0. Asserting rst mid-digit gives AN=FF and SEG=7F within the same cycle.
